// File: rtl/penc_pkg.sv
// Shared definitions for the sequential priority encoder (prio_encoder_seq).
package penc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } penc_state_e;

  // Index value that means "no request".
  localparam int unsigned idx_none = 0;

endpackage

// File: rtl/prio_encoder_seq_find.sv
// penc_find: highest-set-bit locator. It returns (bit position + 1), so that
// index 0 is reserved for an empty vector.
module penc_find
  import penc_pkg::*;
#(
  parameter int unsigned N = 9,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Later (higher) bits overwrite earlier ones, which gives the highest index priority.
  always_comb begin
    idx_o = W'(idx_none);
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = W'(i + 1);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/prio_encoder_seq.sv
// prio_encoder_seq: clocked, parametrised successor of the 74x147-style
// active-low priority encoder. It captures an active-low request vector on
// sample_i, then emits one active-low index per valid/ready handshake,
// highest index first.
// Optional feature: define PENC_MERGE_EN so that a sample_i during SCAN merges
// new requests into the pending set.
module prio_encoder_seq
  import penc_pkg::*;
#(
  parameter int unsigned N = 9,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] I_n,
  input  logic         sample_i,
  output logic [W-1:0] Y_n,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         busy_o,
  output logic [W-1:0] pend_o,
  output logic         done_o
);

  penc_state_e  state_q;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [N-1:0] pend_clr;
  logic [W-1:0] y_n_q;
  logic         valid_q;
  logic         busy_q;
  logic [W-1:0] pend_q;
  logic         done_q;

  logic [N-1:0] req;
  logic         accept;
  logic [W-1:0] cur_idx;
  logic [W-1:0] nxt_idx;
  logic         nxt_any;
  logic [W-1:0] cnt_d;

  assign req     = ~I_n;
  assign accept  = valid_q && ready_i;
  assign cur_idx = ~y_n_q;

  // Pending set with the currently presented index removed on accept.
  always_comb begin
    pend_clr = pending_q;
    if (accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (W'(i + 1) == cur_idx) pend_clr[i] = 1'b0;
      end
    end
  end

  // Next pending set. The clear is applied before the merge, so a request that
  // is accepted and re-asserted on the same edge stays pending.
  always_comb begin
    pending_d = pending_q;
    unique case (state_q)
      IDLE: if (sample_i) pending_d = req;
      SCAN: begin
        pending_d = pend_clr;
`ifdef PENC_MERGE_EN
        if (sample_i) pending_d = pend_clr | req;
`endif
      end
      default: pending_d = pending_q;
    endcase
  end

  // Number of requests in the next pending set.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d = cnt_d + W'(pending_d[i]);
    end
  end

  penc_find #(.N(N), .W(W)) u_find (
    .vec_i (pending_d),
    .idx_o (nxt_idx),
    .any_o (nxt_any)
  );

  // FSM, pending register and registered outputs. Y_n and pend_o are reloaded
  // only on capture or accept, so they hold stable through a stall even when
  // requests are merged into the pending set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      y_n_q     <= '1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      pend_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= nxt_any;
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sample_i) begin
            if (nxt_any) begin
              state_q <= SCAN;
              valid_q <= 1'b1;
              y_n_q   <= ~nxt_idx;
              pend_q  <= cnt_d;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (accept) begin
            if (nxt_any) begin
              y_n_q  <= ~nxt_idx;
              pend_q <= cnt_d;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              y_n_q   <= '1;
              pend_q  <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Y_n     = y_n_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign pend_o  = pend_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Scoreboard bench for prio_encoder_seq (N=9, W=4).
module tb_prio_encoder_seq;

  logic       clk;
  logic       rst_n;
  logic [8:0] I_n;
  logic       sample_i;
  logic [3:0] Y_n;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic [3:0] pend_o;
  logic       done_o;

  prio_encoder_seq #(.N(9), .W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I_n      (I_n),
    .sample_i (sample_i),
    .Y_n      (Y_n),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .busy_o   (busy_o),
    .pend_o   (pend_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input int cnt);
    exp_t e;
    e.y   = ~4'(idx);
    e.cnt = 4'(cnt);
    return e;
  endfunction

  // Reference: emit highest set request first, count is what remains before the accept.
  task automatic push_model(input logic [8:0] in_n);
    logic [8:0] p;
    p = ~in_n;
    for (int k = 8; k >= 0; k--) begin
      if (p[k]) begin
        sb.push_back(mk(k + 1, $countones(p)));
        p[k] = 1'b0;
      end
    end
  endtask

  // Each handshake pops one expected index and compares it.
  always @(negedge clk) begin
    if (mon_en && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected", {28'd0, Y_n}, 32'hF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("y_n", {28'd0, Y_n}, {28'd0, e.y});
        check_eq("pend", {28'd0, pend_o}, {28'd0, e.cnt});
        check_eq("busy", {31'd0, busy_o}, 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [8:0] v);
    I_n      = v;
    sample_i = 1'b1;
    step();
    sample_i = 1'b0;
    I_n      = 9'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valid_o && n < 20) begin
      step();
      n++;
    end
    check_eq("valid_timeout", {31'd0, valid_o}, 32'd1);
  endtask

  // Wait for the done pulse, then confirm idle outputs and that it is one cycle wide.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", {31'd0, done_o}, 32'd1);
    check_eq("done_valid", {31'd0, valid_o}, 32'd0);
    check_eq("done_y", {28'd0, Y_n}, 32'hF);
    check_eq("done_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check_eq("done_pulse", {31'd0, done_o}, 32'd0);
    check_eq("sb_drain", sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    ready_i  = 1'b0;
    sample_i = 1'b0;
    I_n      = '1;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      I_n      = 9'($urandom);
      sample_i = 1'($urandom);
      ready_i  = 1'($urandom);
      step();
    end
    sample_i = 1'b0;
    ready_i  = 1'b0;
    @(negedge clk);
    check_eq("rst_y", {28'd0, Y_n}, 32'hF);
    check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_pend", {28'd0, pend_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // 2: single request (index 5)
    ready_i = 1'b1;
    push_model(9'd495);
    sample(9'd495);
    wait_done();

    // 3: four requests streamed back to back
    push_model(9'd333);
    sample(9'd333);
    wait_done();

    // 4: stall after the first valid
    ready_i = 1'b0;
    push_model(9'd333);
    sample(9'd333);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_y", {28'd0, Y_n}, 32'h7);
      check_eq("stall_pend", {28'd0, pend_o}, 32'd4);
      check_eq("stall_valid", {31'd0, valid_o}, 32'd1);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    wait_done();

    // 5: no requests
    ready_i = 1'b1;
    sample(9'h1FF);
    @(negedge clk);
    check_eq("empty_done", {31'd0, done_o}, 32'd1);
    check_eq("empty_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    check_eq("empty_done_pulse", {31'd0, done_o}, 32'd0);
    check_eq("empty_valid2", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;

    // 6a: reset mid-scan after index 8 is accepted
    ready_i = 1'b0;
    sb.push_back(mk(8, 4));
    sample(9'd333);
    wait_valid();
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_y", {28'd0, Y_n}, 32'hF);
    check_eq("midrst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("midrst_pend", {28'd0, pend_o}, 32'd0);
    check_eq("midrst_done", {31'd0, done_o}, 32'd0);
    check_eq("midrst_sb", sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1;

    // 6b: sample during SCAN while stalled
    ready_i = 1'b0;
`ifdef PENC_MERGE_EN
    sb.push_back(mk(8, 4));
    sb.push_back(mk(6, 4));
    sb.push_back(mk(5, 3));
    sb.push_back(mk(2, 2));
    sb.push_back(mk(1, 1));
`else
    push_model(9'd333);
`endif
    sample(9'd333);
    wait_valid();
    sample(9'h1FE);
    @(negedge clk);
    check_eq("merge_hold_y", {28'd0, Y_n}, 32'h7);
    check_eq("merge_hold_pend", {28'd0, pend_o}, 32'd4);
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    wait_done();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
